// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package sync_fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n producers; never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first request strictly above last_idx, wrapping to index 0.
module rr_priority_picker
    import sync_fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   pick,
    output logic               any_valid
);

    logic [NUM_REQ-1:0]   masked;
    logic [2*NUM_REQ-1:0] dbl;

    // Lower copy holds only requests above last_idx, upper copy covers the wrap.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (i > int'(last_idx));
        end
        dbl       = {req, masked};
        any_valid = |req;
        pick      = '0;
        for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pick = IDX_W'(i % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/sync_fifo_write_arbiter.sv
// Shares the FIFO write port between NUM_REQ producers: round-robin, burst lock,
// idle timeout.
module sync_fifo_write_arbiter
    import sync_fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned IDLE_TIMEOUT = 16,
    localparam int unsigned IDX_W        = idx_width(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_write_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int unsigned    CNT_W    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic           TO_EN    = (IDLE_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [IDX_W-1:0]   idx_d, rr_q, rr_d, pick;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_d, busy_d, any_valid;
    logic               locked, owner_valid, accept, last_accept, timeout_hit;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (req_valid_i),
        .last_idx  (rr_q),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // Owner-side datapath; full gates the write with no added latency.
    assign locked         = (state_q == ARB_LOCKED);
    assign owner_valid    = locked && req_valid_i[grant_idx_o];
    assign accept         = owner_valid && !fifo_full_i;
    assign last_accept    = accept && req_last_i[grant_idx_o];
    assign timeout_hit    = TO_EN && locked && !owner_valid && (cnt_q == CNT_LAST);
    assign req_ready_o    = grant_o & {NUM_REQ{!fifo_full_i}};
    assign fifo_write_o   = accept;
    assign fifo_wr_data_o = locked ? data_arr[grant_idx_o] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            grant_o     <= '0;
            grant_idx_o <= '0;
            rr_q        <= IDX_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_o     <= grant_d;
            grant_idx_o <= idx_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            busy_o      <= busy_d;
            timeout_o   <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_o;
        idx_d     = grant_idx_o;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (any_valid) begin
                    state_d = ARB_LOCKED;
                    grant_d = NUM_REQ'(1) << pick;
                    idx_d   = pick;
                    rr_d    = pick;
                end
            end
            ARB_LOCKED: begin
                if (last_accept || timeout_hit) begin
                    state_d   = ARB_IDLE;
                    grant_d   = '0;
                    cnt_d     = '0;
                    timeout_d = timeout_hit;
                end else if (owner_valid) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d == ARB_LOCKED);
    end

    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant_o));
    a_write_not_full: assert property (@(posedge clk_i) disable iff (rst_i) fifo_write_o |-> !fifo_full_i);
    a_write_busy: assert property (@(posedge clk_i) disable iff (rst_i) fifo_write_o |-> busy_o);

endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// Bench for sync_fifo_write_arbiter: directed scenarios plus random traffic vs. a behavioural model.
module tb_sync_fifo_write_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid, last, ready, grant;
    logic [N*DW-1:0] data;
    logic            full, wr, busy, tmo;
    logic [DW-1:0]   wr_data;
    logic [IW-1:0]   gidx;

    always #5 clk = ~clk;

    sync_fifo_write_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (valid),
        .req_last_i     (last),
        .req_data_i     (data),
        .req_ready_o    (ready),
        .fifo_full_i    (full),
        .fifo_write_o   (wr),
        .fifo_wr_data_o (wr_data),
        .grant_o        (grant),
        .grant_idx_o    (gidx),
        .busy_o         (busy),
        .timeout_o      (tmo)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner or nothing, last granted index, count of idle owner cycles.
    bit m_busy, m_to, armed;
    int m_gidx, m_rr, m_idle;

    initial begin
        armed = 1'b0; m_busy = 1'b0; m_to = 1'b0;
        m_gidx = 0; m_rr = N - 1; m_idle = 0;
    end

    always @(posedge clk) begin : model
        bit found;
        int cand;
        if (rst) begin
            armed = 1'b1; m_busy = 1'b0; m_to = 1'b0;
            m_gidx = 0; m_rr = N - 1; m_idle = 0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = (m_rr + k) % N;
                if (!found && valid[cand]) begin
                    found = 1'b1;
                    m_busy = 1'b1; m_gidx = cand; m_rr = cand; m_idle = 0;
                end
            end
        end else begin
            m_to = 1'b0;
            if (valid[m_gidx]) begin
                m_idle = 0;
                if (!full && last[m_gidx]) m_busy = 1'b0;
            end else begin
                m_idle++;
                if (TO != 0 && m_idle == TO) begin
                    m_busy = 1'b0; m_to = 1'b1; m_idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0]  eg;
        logic          ew;
        logic [DW-1:0] ed;
        if (armed) begin
            eg = '0;
            if (m_busy) eg[m_gidx] = 1'b1;
            ew = m_busy && valid[m_gidx] && !full;
            ed = m_busy ? data[m_gidx*DW +: DW] : '0;
            chk("grant",     64'(grant),   64'(eg));
            chk("grant_idx", 64'(gidx),    64'(m_gidx[IW-1:0]));
            chk("busy",      64'(busy),    64'(m_busy));
            chk("timeout",   64'(tmo),     64'(m_to));
            chk("ready",     64'(ready),   64'(full ? '0 : eg));
            chk("write",     64'(wr),      64'(ew));
            chk("wr_data",   64'(wr_data), 64'(ed));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_word(input int p, input logic [DW-1:0] w);
        data[p*DW +: DW] = w;
    endtask

    logic [N-1:0] exp_rr [8];
    int           wr_cnt;
    int           dens;

    initial begin
        rst = 1'b1; valid = '1; last = '0; data = '0; full = 1'b0;
        exp_rr = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};

        // Reset with everyone requesting, then producer 0 wins first.
        tick(); tick();
        rst = 1'b0; last = '1;
        at_neg();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_write", 64'(wr),    64'(0));
        chk("rst_busy",  64'(busy),  64'(0));
        tick();
        at_neg();
        chk("first_grant", 64'(grant), 64'(4'b0001));
        tick();
        valid = '0; last = '0;
        tick(); tick();

        // Single 3-beat burst from producer 1.
        valid = 4'b0010; set_word(1, 32'hA1);
        tick(); at_neg();
        chk("burst_grant", 64'(grant),   64'(4'b0010));
        chk("burst_a1",    64'(wr_data), 64'(32'hA1));
        chk("burst_w1",    64'(wr),      64'(1));
        tick(); set_word(1, 32'hA2); at_neg();
        chk("burst_a2", 64'(wr_data), 64'(32'hA2));
        tick(); set_word(1, 32'hA3); last = 4'b0010; at_neg();
        chk("burst_a3", 64'(wr_data), 64'(32'hA3));
        chk("burst_w3", 64'(wr),      64'(1));
        tick(); valid = '0; last = '0; at_neg();
        chk("burst_end", 64'(grant), 64'(0));

        // Round robin with 1-beat bursts after a fresh reset.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; valid = '1; last = '1;
        for (int p = 0; p < int'(N); p++) set_word(p, 32'h100 + p);
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) begin valid = '0; last = '0; end
            at_neg();
            chk("rr_grant", 64'(grant), 64'(exp_rr[i]));
            wr_cnt += int'(wr);
        end
        chk("rr_writes", 64'(wr_cnt), 64'(4));

        // Backpressure mid-burst on producer 2.
        tick(); valid = 4'b0100; set_word(2, 32'hB0);
        tick(); at_neg();
        chk("bp_b0", 64'(wr_data), 64'(32'hB0));
        tick(); set_word(2, 32'hB1); at_neg();
        chk("bp_b1", 64'(wr_data), 64'(32'hB1));
        tick(); set_word(2, 32'hB2); full = 1'b1;
        for (int j = 0; j < 5; j++) begin
            at_neg();
            chk("bp_ready", 64'(ready), 64'(0));
            chk("bp_write", 64'(wr),    64'(0));
            chk("bp_tmo",   64'(tmo),   64'(0));
            tick();
            if (j == 4) full = 1'b0;
        end
        at_neg();
        chk("bp_resume_w", 64'(wr),      64'(1));
        chk("bp_resume_d", 64'(wr_data), 64'(32'hB2));
        tick(); set_word(2, 32'hB3); last = 4'b0100; at_neg();
        chk("bp_b3", 64'(wr_data), 64'(32'hB3));
        tick(); valid = '0; last = '0; at_neg();
        chk("bp_end", 64'(grant), 64'(0));

        // Timeout: producer 0 stalls while producer 3 waits.
        tick(); valid = 4'b0001; set_word(0, 32'hC0);
        tick(); at_neg();
        chk("to_grant0", 64'(grant), 64'(4'b0001));
        tick(); valid = 4'b1000; set_word(3, 32'hD0);
        for (int k = 0; k < int'(TO); k++) begin
            at_neg();
            chk("to_hold", 64'(grant), 64'(4'b0001));
            chk("to_quiet", 64'(tmo),  64'(0));
            tick();
        end
        last = 4'b1000;
        at_neg();
        chk("to_pulse",   64'(tmo),   64'(1));
        chk("to_release", 64'(grant), 64'(0));
        tick(); at_neg();
        chk("to_next", 64'(grant), 64'(4'b1000));
        chk("to_once", 64'(tmo),   64'(0));
        tick(); valid = '0; last = '0;

        // Reset mid-burst after two beats of producer 2.
        tick(); valid = 4'b0100; set_word(2, 32'hE0);
        tick(); at_neg();
        chk("mid_e0", 64'(wr_data), 64'(32'hE0));
        tick(); set_word(2, 32'hE1); rst = 1'b1; at_neg();
        chk("mid_e1", 64'(wr_data), 64'(32'hE1));
        tick(); rst = 1'b0; valid = 4'b0101; last = 4'b0001; set_word(0, 32'hF0); set_word(2, 32'hE2);
        at_neg();
        chk("mid_nowrite", 64'(wr),    64'(0));
        chk("mid_grant0",  64'(grant), 64'(0));
        tick(); at_neg();
        chk("mid_p0_first", 64'(grant), 64'(4'b0001));
        tick(); valid = '0; last = '0;
        tick();

        // Random traffic with varying request density, backpressure and rare resets.
        dens = 2;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 64 == 0) dens = int'($urandom_range(0, 4));
            rst = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < int'(N); p++) begin
                valid[p] = (int'($urandom_range(0, 3)) < dens);
                last[p]  = ($urandom_range(0, 2) == 0);
                set_word(p, $urandom());
            end
            full = ($urandom_range(0, 3) == 0);
        end
        tick(); rst = 1'b0; valid = '0; last = '0; full = 1'b0;
        tick();
        at_neg();
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
